// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_LEN = 3'd0,
    COLLECT  = 3'd1,
    WRITE    = 3'd2,
    CHECK    = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

endpackage

// File: rtl/loader_idle_timer.sv
// Idle-cycle counter that bounds the gap between accepted bytes of a frame.
module loader_idle_timer #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] count;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         count <= '0;
    else if (clear)                  count <= '0;
    else if (run && count != LIMIT)  count <= count + 16'd1;
  end

  // High in the idle cycle whose tick brings the count to TIMEOUT, so the FSM leaves on that edge.
  assign expired = run && !clear && (count == LIMIT - 16'd1);

endmodule

// File: rtl/imem_loader.sv
// Frames a boot byte stream into 32-bit words, writes them to instruction memory,
// and releases the core once the XOR checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_wren,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int BI_W = $clog2(BYTES_PER_WORD);
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES_PER_WORD - 1);

  state_t                     state;
  logic [ADDR_W:0]            word_total;
  logic [ADDR_W:0]            word_idx;
  logic [ADDR_W:0]            word_next;
  logic [BI_W-1:0]            byte_idx;
  logic [WORD_W-BYTE_W-1:0]   word_sr;
  logic [BYTE_W-1:0]          xor_acc;
  logic                       accept;
  logic                       timer_run;
  logic                       timer_clear;
  logic                       timer_expired;

  assign in_ready = (state == WAIT_LEN) || (state == COLLECT) || (state == CHECK);
  assign im_wren  = (state == WRITE);
  assign done     = (state == DONE);
  assign error    = (state == ERROR);
  assign cpu_hold = (state != DONE);

  assign accept      = in_valid && in_ready;
  assign word_next   = word_idx + 1'b1;
  assign timer_run   = ((state == COLLECT) || (state == CHECK)) && !in_valid;
  assign timer_clear = accept || reload || (state == WAIT_LEN);

  loader_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (timer_run),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LEN;
      word_total <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      xor_acc    <= '0;
      im_addr    <= '0;
      im_data    <= '0;
    end else if (reload) begin
      // Reload wins over any byte offered in the same cycle; that byte is dropped.
      state <= WAIT_LEN;
    end else begin
      case (state)
        WAIT_LEN: if (accept) begin
          // A count of zero encodes a full 2^ADDR_W-word image.
          word_total <= (in_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(in_data);
          word_idx   <= '0;
          byte_idx   <= '0;
          xor_acc    <= '0;
          state      <= COLLECT;
        end
        COLLECT: begin
          if (accept) begin
            word_sr  <= {word_sr[WORD_W-2*BYTE_W-1:0], in_data};
            xor_acc  <= xor_acc ^ in_data;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == LAST_BYTE) begin
              im_addr <= word_idx[ADDR_W-1:0];
              im_data <= {word_sr, in_data};
              state   <= WRITE;
            end
          end else if (timer_expired) begin
            state <= ERROR;
          end
        end
        WRITE: begin
          word_idx <= word_next;
          state    <= (word_next == word_total) ? CHECK : COLLECT;
        end
        CHECK: begin
          if (accept)             state <= (in_data == xor_acc) ? DONE : ERROR;
          else if (timer_expired) state <= ERROR;
        end
        DONE:    state <= DONE;
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: frames are built from a word list,
// expected writes are queued as words are sent, and a monitor checks each write.
module tb_imem_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, im_wren, cpu_hold, done, error;
  logic [7:0]  im_addr;
  logic [31:0] im_data;

  logic        to_reload = 1'b0;
  logic [7:0]  to_data = '0;
  logic        to_valid = 1'b0;
  logic        to_ready, to_wren, to_hold, to_done, to_error;
  logic [7:0]  to_addr;
  logic [31:0] to_wdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          to_wren_cnt = 0;
  wr_t         exp_q[$];
  logic [31:0] frame_words[256];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .TIMEOUT(200)) dut (
    .clk(clk), .rst(rst), .reload(reload), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_wren(im_wren), .im_addr(im_addr), .im_data(im_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  imem_loader #(.ADDR_W(8), .TIMEOUT(50)) dut_to (
    .clk(clk), .rst(rst), .reload(to_reload), .in_data(to_data), .in_valid(to_valid),
    .in_ready(to_ready), .im_wren(to_wren), .im_addr(to_addr), .im_data(to_wdata),
    .cpu_hold(to_hold), .done(to_done), .error(to_error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest queued expectation and block input.
  always @(negedge clk) begin
    if (!rst && im_wren) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, im_addr, im_data}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(im_addr), 64'(e.addr));
        check("write_data", 64'(im_data), 64'(e.data));
      end
      check("ready_in_write", 64'(in_ready), 64'd0);
    end
    if (!rst && to_wren) to_wren_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("accept_bound", 64'd0, 64'd1);
  endtask

  // ck_override < 0 sends the true checksum; otherwise that byte is sent instead.
  task automatic send_frame(input int n, input int ck_override, input int gap_max);
    logic [7:0] ck, b, sent;
    bit good;
    ck = '0;
    send_byte(8'(n), gap_max);
    for (int w = 0; w < n; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b  = frame_words[w][8*k +: 8];
        ck = ck ^ b;
        send_byte(b, gap_max);
      end
      exp_q.push_back('{addr: 8'(w), data: frame_words[w]});
    end
    sent = (ck_override < 0) ? ck : 8'(ck_override);
    good = (sent == ck);
    send_byte(sent, gap_max);
    check("release_hold", 64'(cpu_hold), 64'(!good));
    check("frame_done",   64'(done),     64'(good));
    check("frame_error",  64'(error),    64'(!good));
    check("ready_after",  64'(in_ready), 64'd0);
    check("writes_left",  64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("reload_ready", 64'(in_ready), 64'd1);
    check("reload_hold",  64'(cpu_hold), 64'd1);
    check("reload_flags", 64'({done, error}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state.
    check("rst_ready",  64'(in_ready), 64'd1);
    check("rst_wren",   64'(im_wren),  64'd0);
    check("rst_addr",   64'(im_addr),  64'd0);
    check("rst_data",   64'(im_data),  64'd0);
    check("rst_hold",   64'(cpu_hold), 64'd1);
    check("rst_flags",  64'({done, error}), 64'd0);

    // Good two-word image, back to back.
    frame_words[0] = 32'h2001_0005;
    frame_words[1] = 32'h8C02_0010;
    send_frame(2, -1, 0);

    // Same image with a wrong checksum byte.
    pulse_reload();
    send_frame(2, 8'h3B, 0);

    // Same image with random gaps, then random images with gaps.
    pulse_reload();
    send_frame(2, -1, 100);
    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int w = 0; w < n; w++) frame_words[w] = $urandom;
      pulse_reload();
      send_frame(n, -1, 100);
    end

    // Full 256-word image, count byte 0.
    for (int w = 0; w < 256; w++) frame_words[w] = 32'(w);
    pulse_reload();
    send_frame(256, -1, 0);

    // Reload mid-frame coinciding with a valid byte.
    pulse_reload();
    for (int w = 0; w < 3; w++) frame_words[w] = $urandom;
    send_byte(8'd3, 0);
    for (int k = 3; k >= 0; k--) send_byte(frame_words[0][8*k +: 8], 0);
    exp_q.push_back('{addr: 8'd0, data: frame_words[0]});
    send_byte(frame_words[1][31:24], 0);
    in_data  = frame_words[1][23:16];
    in_valid = 1'b1;
    reload   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reload   = 1'b0;
    check("midreload_ready", 64'(in_ready), 64'd1);
    check("midreload_hold",  64'(cpu_hold), 64'd1);
    check("midreload_wq",    64'(exp_q.size()), 64'd0);
    for (int w = 0; w < 4; w++) frame_words[w] = $urandom;
    send_frame(4, -1, 3);

    // Timeout on the TIMEOUT=50 instance, idle in WAIT_LEN until now.
    check("to_idle_wait", 64'({to_error, to_ready}), 64'd1);
    to_data  = 8'h01;
    to_valid = 1'b1;
    @(posedge clk); #1;
    to_data  = 8'hAA;
    @(posedge clk); #1;
    to_valid = 1'b0;
    repeat (49) begin @(posedge clk); #1; end
    check("to_before", 64'(to_error), 64'd0);
    @(posedge clk); #1;
    check("to_error",  64'(to_error), 64'd1);
    check("to_hold",   64'(to_hold),  64'd1);
    check("to_nowrite", 64'(to_wren_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
